// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing, byte width and the TX arbiter
// state encoding used by uart_tx_arbiter.
package uart_pkg;

  localparam int CLK_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int DATA_WIDTH  = 8;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_START     = 2'd1,
    ARB_WAIT_DONE = 2'd2
  } arb_state_t;

  // Index after k, wrapping at n back to 0.
  function automatic int wrap_inc(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: the first valid requester found
// when scanning ptr, ptr+1, ... modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // order[i] is the requester visited at search position i
  logic [IDX_W-1:0] order [N_REQ];

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_order
    assign order[gi] = IDX_W'((int'(ptr) + gi) % N_REQ);
  end

  // Scan from the far end so the position closest to ptr wins last
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid[order[i]]) begin
        found = 1'b1;
        index = order[i];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ byte producers share one UART
// transmitter. One byte is in flight at a time; a missing tx_done is
// caught by a watchdog that raises o_err and frees the transmitter.
// N_REQ must be at least 2.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 10000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [N_REQ-1:0]              i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_data,
  output logic [N_REQ-1:0]              o_req_ready,
  output logic                          o_tx_start,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  input  logic                          i_tx_busy,
  input  logic                          i_tx_done,
  output logic [$clog2(N_REQ)-1:0]      o_grant_id,
  output logic                          o_busy,
  output logic                          o_err
);

  import uart_pkg::arb_state_t;
  import uart_pkg::ARB_IDLE;
  import uart_pkg::ARB_START;
  import uart_pkg::ARB_WAIT_DONE;
  import uart_pkg::wrap_inc;

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t              state_reg, state_next;
  logic [IDX_W-1:0]        ptr_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [IDX_W-1:0]        gid_reg;
  logic                    err_reg;

  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic                    xfer;
  logic                    timeout_hit;
  logic [DATA_WIDTH-1:0]   req_byte [N_REQ];

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid (i_req_valid),
    .ptr   (ptr_reg),
    .found (pick_found),
    .index (pick_idx)
  );

  // A transfer happens in the IDLE cycle where a winner exists and the
  // transmitter is free; reset masks it so ready stays low during reset.
  assign xfer = i_rst_n && (state_reg == ARB_IDLE) && !i_tx_busy && pick_found;

  // Done takes priority over the terminal count.
  assign timeout_hit = (state_reg == ARB_WAIT_DONE) && !i_tx_done && (cnt_reg == CNT_LAST);

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_byte[gi]    = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign o_req_ready[gi] = xfer && (pick_idx == IDX_W'(gi));
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_next = ARB_IDLE;
    case (state_reg)
      ARB_IDLE:      state_next = xfer ? ARB_START : ARB_IDLE;
      ARB_START:     state_next = ARB_WAIT_DONE;
      ARB_WAIT_DONE: state_next = (i_tx_done || timeout_hit) ? ARB_IDLE : ARB_WAIT_DONE;
      default:       state_next = ARB_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_tx_start = (state_reg == ARB_START);
    o_busy     = (state_reg != ARB_IDLE);
  end

  // Datapath: latch the winning byte, advance the pointer, run the watchdog
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_reg  <= '0;
      cnt_reg  <= '0;
      data_reg <= '0;
      gid_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      err_reg <= timeout_hit;
      if (xfer) begin
        data_reg <= req_byte[pick_idx];
        gid_reg  <= pick_idx;
        ptr_reg  <= IDX_W'(wrap_inc(int'(pick_idx), N_REQ));
      end
      if (state_reg == ARB_START) begin
        cnt_reg <= '0;
      end else if (state_reg == ARB_WAIT_DONE) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign o_tx_data  = data_reg;
  assign o_grant_id = gid_reg;
  assign o_err      = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transaction-level reference
// model checked every cycle, plus literal expectations for key scenarios.
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 40;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic [N_REQ-1:0]      i_req_valid;
  logic [N_REQ*DW-1:0]   i_req_data;
  logic [N_REQ-1:0]      o_req_ready;
  logic                  o_tx_start;
  logic [DW-1:0]         o_tx_data;
  logic                  i_tx_busy;
  logic                  i_tx_done;
  logic [1:0]            o_grant_id;
  logic                  o_busy;
  logic                  o_err;

  int checks = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .i_tx_busy   (i_tx_busy),
    .i_tx_done   (i_tx_done),
    .o_grant_id  (o_grant_id),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  // phase: 0 = free, 1 = start pulse, 2 = byte on the wire
  bit        m_init = 1'b0;
  int        m_phase = 0;
  int        m_elapsed = 0;
  int        m_ptr = 0;
  int        m_gid = 0;
  logic [7:0] m_data = 8'h00;
  bit        m_err = 1'b0;

  function automatic int pick(input logic [N_REQ-1:0] v, input int p);
    for (int off = 0; off < N_REQ; off++) begin
      if (v[(p + off) % N_REQ]) return (p + off) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [N_REQ*DW-1:0] d, input int k);
    return d[8*k +: 8];
  endfunction

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_init    <= 1'b1;
      m_phase   <= 0;
      m_elapsed <= 0;
      m_ptr     <= 0;
      m_gid     <= 0;
      m_data    <= 8'h00;
      m_err     <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (m_phase == 0) begin
        if (!i_tx_busy && pick(i_req_valid, m_ptr) >= 0) begin
          m_phase <= 1;
          m_gid   <= pick(i_req_valid, m_ptr);
          m_data  <= byte_of(i_req_data, pick(i_req_valid, m_ptr));
          m_ptr   <= (pick(i_req_valid, m_ptr) + 1) % N_REQ;
        end
      end else if (m_phase == 1) begin
        m_phase   <= 2;
        m_elapsed <= 0;
      end else begin
        if (i_tx_done) begin
          m_phase <= 0;
        end else if (m_elapsed == TIMEOUT - 1) begin
          m_phase <= 0;
          m_err   <= 1'b1;
        end else begin
          m_elapsed <= m_elapsed + 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    int w;
    logic [N_REQ-1:0] er;
    w  = pick(i_req_valid, m_ptr);
    er = '0;
    if (i_rst_n && m_phase == 0 && !i_tx_busy && w >= 0) er[w] = 1'b1;
    chk("cyc_ready", 32'(o_req_ready), 32'(er));
    chk("cyc_start", 32'(o_tx_start), 32'(m_phase == 1));
    chk("cyc_busy",  32'(o_busy),     32'(m_phase != 0));
    chk("cyc_err",   32'(o_err),      32'(m_err));
    chk("cyc_data",  32'(o_tx_data),  32'(m_data));
    chk("cyc_gid",   32'(o_grant_id), 32'(m_gid));
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (o_tx_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_start", 32'(o_tx_start), 32'd1);
    $display("txn grant=%0d data=0x%02h t=%0t", o_grant_id, o_tx_data, $time);
  endtask

  task automatic finish_byte(input int gap);
    repeat (gap) tick();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_order [5];
    int n;
    int nz;

    exp_order = '{0, 1, 2, 3, 0};
    i_rst_n     = 1'b0;
    i_req_valid = 4'b1111;
    i_req_data  = 32'h0;
    i_tx_busy   = 1'b0;
    i_tx_done   = 1'b0;

    fork
      forever begin
        @(negedge i_clk);
        if (m_init) compare_cycle();
      end
      begin
        repeat (20000) @(posedge i_clk);
        $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values, with requests present while reset is held
    repeat (3) tick();
    chk("rst_ready", 32'(o_req_ready), 32'h0);
    chk("rst_busy",  32'(o_busy),      32'h0);
    chk("rst_data",  32'(o_tx_data),   32'h00);
    chk("rst_gid",   32'(o_grant_id),  32'h0);
    i_req_valid = 4'b0000;
    i_rst_n     = 1'b1;
    tick();

    // Single request from requester 2
    i_req_valid = 4'b0100;
    i_req_data  = 32'h0041_0000;
    #1;
    chk("single_ready", 32'(o_req_ready), 32'b0100);
    tick();
    i_req_valid = 4'b0000;
    i_tx_done   = 1'b1;          // must be ignored in the start cycle
    #1;
    chk("single_start", 32'(o_tx_start), 32'd1);
    chk("single_data",  32'(o_tx_data),  32'h41);
    chk("single_gid",   32'(o_grant_id), 32'd2);
    $display("txn grant=%0d data=0x%02h t=%0t", o_grant_id, o_tx_data, $time);
    tick();
    i_tx_done = 1'b0;
    #1;
    chk("done_ignored_in_start", 32'(o_busy), 32'd1);
    finish_byte(5);
    chk("single_back_idle", 32'(o_busy), 32'd0);

    // Round robin with all four continuously valid
    do_reset();
    i_req_valid = 4'b1111;
    i_req_data  = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      wait_start(100);
      chk("rr_order", 32'(o_grant_id), 32'(exp_order[i]));
      chk("rr_data",  32'(o_tx_data),  32'(8'h10 + exp_order[i]));
      finish_byte(20);
    end
    i_req_valid = 4'b0000;
    tick();

    // Transmitter busy blocks the handshake
    do_reset();
    i_tx_busy   = 1'b1;
    i_req_valid = 4'b0001;
    i_req_data  = 32'h0000_00AA;
    nz = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (o_req_ready != 4'b0000) nz++;
      tick();
    end
    chk("busy_block", 32'(nz), 32'd0);
    i_tx_busy = 1'b0;
    #1;
    chk("busy_release_ready", 32'(o_req_ready), 32'b0001);
    tick();
    i_req_valid = 4'b0000;
    chk("busy_release_start", 32'(o_tx_start), 32'd1);
    chk("busy_release_data",  32'(o_tx_data),  32'hAA);
    finish_byte(3);

    // Timeout, then the pending requester 2 is served
    do_reset();
    i_req_valid = 4'b0101;
    i_req_data  = 32'h0066_0055;
    wait_start(10);
    chk("to_gid",  32'(o_grant_id), 32'd0);
    chk("to_data", 32'(o_tx_data),  32'h55);
    i_req_valid = 4'b0100;
    n = 0;
    while (o_err !== 1'b1 && n < TIMEOUT + 20) begin
      tick();
      n++;
    end
    chk("to_latency", 32'(n), 32'(TIMEOUT + 1));
    chk("to_idle",    32'(o_busy), 32'd0);
    chk("to_next_ready", 32'(o_req_ready), 32'b0100);
    tick();
    i_req_valid = 4'b0000;
    chk("to_err_single", 32'(o_err), 32'd0);
    chk("to_next_start", 32'(o_tx_start), 32'd1);
    chk("to_next_gid",   32'(o_grant_id), 32'd2);
    chk("to_next_data",  32'(o_tx_data),  32'h66);
    finish_byte(4);

    // Reset in the middle of a byte
    do_reset();
    i_req_valid = 4'b1001;
    i_req_data  = 32'hCC00_00BB;
    wait_start(10);
    chk("mid_rst_first", 32'(o_tx_data), 32'hBB);
    i_req_valid = 4'b1000;
    repeat (5) tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    #1;
    chk("mid_rst_busy",  32'(o_busy),      32'd0);
    chk("mid_rst_data",  32'(o_tx_data),   32'h00);
    chk("mid_rst_gid",   32'(o_grant_id),  32'd0);
    chk("mid_rst_err",   32'(o_err),       32'd0);
    chk("mid_rst_ready", 32'(o_req_ready), 32'b1000);
    tick();
    i_req_valid = 4'b0000;
    chk("mid_rst_gid3",  32'(o_grant_id),  32'd3);
    chk("mid_rst_data3", 32'(o_tx_data),   32'hCC);
    finish_byte(2);

    // Done coincident with the terminal count
    do_reset();
    i_req_valid = 4'b0001;
    i_req_data  = 32'h0000_0077;
    wait_start(10);
    i_req_valid = 4'b0000;
    repeat (TIMEOUT) tick();
    chk("tc_still_busy", 32'(o_busy), 32'd1);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    chk("tc_err", 32'(o_err),  32'd0);
    chk("tc_idle", 32'(o_busy), 32'd0);
    tick();
    chk("tc_err_next", 32'(o_err), 32'd0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
